// File: rtl/adpll_pkg.sv
// Shared ADPLL divider constants and the divide-control state encoding.
package adpll_pkg;

  localparam int unsigned NDIV_W = 4;
  localparam int unsigned FRAC_W = 4;

  localparam logic [NDIV_W-1:0] NDIV_MIN = 4'd2;
  localparam logic [NDIV_W-1:0] NDIV_MAX = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_RUN
  } seq_state_e;

  // Divide values below the divider's minimum are raised to the minimum.
  function automatic logic [NDIV_W-1:0] coerce_ndiv(input logic [NDIV_W-1:0] n);
    return (n < NDIV_MIN) ? NDIV_MIN : n;
  endfunction

endpackage

// File: rtl/ndiv_frac_accum.sv
// Fractional phase accumulator: steps by F per divider period and yields
// the dithered divide value N + carry, clamped to the divider maximum.
module ndiv_frac_accum
  import adpll_pkg::*;
(
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              step_i,
  input  logic              clear_i,
  input  logic [FRAC_W-1:0] frac_i,
  input  logic [NDIV_W-1:0] n_i,
  output logic              carry_o,
  output logic [NDIV_W-1:0] ndiv_o
);

  logic [FRAC_W-1:0] acc_q;
  logic [FRAC_W:0]   sum;
  logic [NDIV_W:0]   n_plus;

  assign sum     = {1'b0, acc_q} + {1'b0, frac_i};
  assign carry_o = sum[FRAC_W];

  // N+c is formed one bit wider so an overflow past the maximum is visible.
  assign n_plus = {1'b0, n_i} + {{NDIV_W{1'b0}}, carry_o};
  assign ndiv_o = (n_plus > {1'b0, NDIV_MAX}) ? NDIV_MAX : n_plus[NDIV_W-1:0];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      acc_q <= '0;
    end else if (clear_i) begin
      acc_q <= '0;
    end else if (step_i) begin
      acc_q <= sum[FRAC_W-1:0];
    end
  end

endmodule

// File: rtl/ndiv_sequencer.sv
// Divide-ratio sequencer for the ADPLL feedback divider: config handshake,
// divider reset control and fractional N/N+1 dithering on divider edges.
module ndiv_sequencer
  import adpll_pkg::*;
#(
  parameter logic [NDIV_W-1:0] DEFAULT_NDIV = 4'd4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [NDIV_W-1:0] cfg_int,
  input  logic [FRAC_W-1:0] cfg_frac,
  input  logic              div_out,
  output logic [NDIV_W-1:0] ndiv,
  output logic              div_reset,
  output logic              ndiv_upd,
  output logic              cfg_err,
  output logic              sat
);

  seq_state_e        state_q;
  logic [NDIV_W-1:0] n_q, pn_q, ndiv_q;
  logic [FRAC_W-1:0] f_q, pf_q;
  logic              pend_q;
  logic              div_reset_q, ndiv_upd_q, cfg_err_q, sat_q;
  logic              div_s_q, div_d_q;

  logic              div_rise;
  logic              accept;
  logic [NDIV_W-1:0] cfg_n;
  logic              acc_step, acc_clear, acc_carry;
  logic [NDIV_W-1:0] acc_ndiv;

  // div_out is sampled once before edge detection, giving a two-cycle
  // path from a divider edge to the registered ndiv.
  assign div_rise  = div_s_q && !div_d_q;
  assign cfg_ready = (state_q == ST_IDLE) || ((state_q == ST_RUN) && !pend_q);
  assign accept    = cfg_valid && cfg_ready;
  assign cfg_n     = coerce_ndiv(cfg_int);

  assign acc_step  = (state_q == ST_RUN) && enable && div_rise && !pend_q;
  assign acc_clear = (state_q == ST_IDLE) || !enable || (div_rise && pend_q);

  ndiv_frac_accum u_accum (
    .clk_i   (clk),
    .reset_i (reset),
    .step_i  (acc_step),
    .clear_i (acc_clear),
    .frac_i  (f_q),
    .n_i     (n_q),
    .carry_o (acc_carry),
    .ndiv_o  (acc_ndiv)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      n_q         <= DEFAULT_NDIV;
      f_q         <= '0;
      pend_q      <= 1'b0;
      pn_q        <= '0;
      pf_q        <= '0;
      ndiv_q      <= DEFAULT_NDIV;
      div_reset_q <= 1'b1;
      ndiv_upd_q  <= 1'b0;
      cfg_err_q   <= 1'b0;
      sat_q       <= 1'b0;
      div_s_q     <= 1'b0;
      div_d_q     <= 1'b0;
    end else begin
      div_s_q    <= div_out;
      div_d_q    <= div_s_q;
      ndiv_upd_q <= 1'b0;
      cfg_err_q  <= accept && (cfg_int < NDIV_MIN);
      if (accept) sat_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          div_reset_q <= 1'b1;
          if (accept) begin
            n_q        <= cfg_n;
            f_q        <= cfg_frac;
            ndiv_q     <= cfg_n;
            ndiv_upd_q <= 1'b1;
          end
          if (enable) state_q <= ST_START;
        end

        ST_START: begin
          if (!enable) begin
            state_q <= ST_IDLE;
          end else begin
            div_reset_q <= 1'b0;
            state_q     <= ST_RUN;
          end
        end

        ST_RUN: begin
          if (!enable) begin
            state_q     <= ST_IDLE;
            div_reset_q <= 1'b1;
            // A config offered on the disable cycle is applied like a pending one.
            if (accept) begin
              n_q        <= cfg_n;
              f_q        <= cfg_frac;
              ndiv_q     <= cfg_n;
              ndiv_upd_q <= 1'b1;
            end else if (pend_q) begin
              n_q        <= pn_q;
              f_q        <= pf_q;
              ndiv_q     <= pn_q;
              ndiv_upd_q <= 1'b1;
              pend_q     <= 1'b0;
            end
          end else begin
            if (div_rise) begin
              if (pend_q) begin
                n_q        <= pn_q;
                f_q        <= pf_q;
                ndiv_q     <= pn_q;
                ndiv_upd_q <= 1'b1;
                pend_q     <= 1'b0;
              end else begin
                ndiv_q     <= acc_ndiv;
                ndiv_upd_q <= (acc_ndiv != ndiv_q);
                // Saturation on this edge outranks a same-cycle clear by acceptance.
                if (acc_carry && (n_q == NDIV_MAX)) sat_q <= 1'b1;
              end
            end
            if (accept) begin
              pend_q <= 1'b1;
              pn_q   <= cfg_n;
              pf_q   <= cfg_frac;
            end
          end
        end

        default: begin
          state_q     <= ST_IDLE;
          div_reset_q <= 1'b1;
        end
      endcase
    end
  end

  assign ndiv      = ndiv_q;
  assign div_reset = div_reset_q;
  assign ndiv_upd  = ndiv_upd_q;
  assign cfg_err   = cfg_err_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_ndiv_sequencer.sv
// Self-checking bench for ndiv_sequencer: a behavioural divide-control model
// plus a simple divider model that produces div_out from the modelled ndiv.
module tb_ndiv_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [3:0] cfg_int = 4'd0;
  logic [3:0] cfg_frac = 4'd0;
  logic       div_out = 1'b0;
  logic       cfg_ready;
  logic [3:0] ndiv;
  logic       div_reset;
  logic       ndiv_upd;
  logic       cfg_err;
  logic       sat;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  ndiv_sequencer #(.DEFAULT_NDIV(4'd4)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_int   (cfg_int),
    .cfg_frac  (cfg_frac),
    .div_out   (div_out),
    .ndiv      (ndiv),
    .div_reset (div_reset),
    .ndiv_upd  (ndiv_upd),
    .cfg_err   (cfg_err),
    .sat       (sat)
  );

  always #5 clk = ~clk;

  // Reference model: 0=idle, 1=start, 2=run
  int m_st = 0;
  int mN = 4, mF = 0, macc = 0, mpN = 0, mpF = 0, mndiv = 4;
  bit mpend = 0, mdivrst = 1, mupd = 0, merr = 0, msat = 0;
  bit s1 = 0, s2 = 0;
  int dcnt = 0;
  bit ddout = 0;
  int m_edges = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task model_reset();
    m_st = 0; mN = 4; mF = 0; macc = 0; mpN = 0; mpF = 0; mndiv = 4;
    mpend = 0; mdivrst = 1; mupd = 0; merr = 0; msat = 0;
    s1 = 0; s2 = 0; dcnt = 0; ddout = 0; div_out = 1'b0;
  endtask

  task apply_cfg(input int n, input int f);
    mN = n; mF = f; macc = 0; mndiv = n; mupd = 1; mpend = 0;
  endtask

  task model_step();
    bit rise, ready, acc_ok;
    int cn, t, c, nd;
    rise = s1 && !s2;
    s2 = s1;
    s1 = div_out;
    ready  = (m_st == 0) || (m_st == 2 && !mpend);
    acc_ok = cfg_valid && ready;
    cn     = (cfg_int < 2) ? 2 : int'(cfg_int);
    merr   = acc_ok && (cfg_int < 2);
    mupd   = 0;
    if (acc_ok) msat = 0;
    // divider: half period of ndiv+1 clocks, held low while in reset
    if (mdivrst) begin dcnt = 0; ddout = 0; end
    else if (dcnt >= mndiv) begin dcnt = 0; ddout = !ddout; end
    else dcnt++;
    case (m_st)
      0: begin
        mdivrst = 1;
        if (acc_ok) apply_cfg(cn, int'(cfg_frac));
        if (enable) m_st = 1;
      end
      1: begin
        if (!enable) m_st = 0;
        else begin mdivrst = 0; m_st = 2; end
      end
      default: begin
        if (!enable) begin
          m_st = 0; mdivrst = 1; macc = 0;
          if (acc_ok) apply_cfg(cn, int'(cfg_frac));
          else if (mpend) apply_cfg(mpN, mpF);
        end else begin
          if (rise) begin
            m_edges++;
            if (mpend) apply_cfg(mpN, mpF);
            else begin
              t = macc + mF; c = t / 16; macc = t % 16;
              nd = mN + c;
              if (nd > 15) begin nd = 15; msat = 1; end
              if (nd != mndiv) mupd = 1;
              mndiv = nd;
            end
          end
          if (acc_ok) begin mpend = 1; mpN = cn; mpF = int'(cfg_frac); end
        end
      end
    endcase
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) model_reset();
    else begin
      model_step();
      #1 div_out = ddout;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ndiv", int'(ndiv), mndiv);
      chk("div_reset", int'(div_reset), int'(mdivrst));
      chk("ndiv_upd", int'(ndiv_upd), int'(mupd));
      chk("cfg_err", int'(cfg_err), int'(merr));
      chk("sat", int'(sat), int'(msat));
      chk("cfg_ready", int'(cfg_ready), int'((m_st == 0) || (m_st == 2 && !mpend)));
    end
  end

  task tick(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task send_cfg(input int n, input int f);
    bit done;
    done = 0;
    cfg_valid = 1'b1; cfg_int = 4'(n); cfg_frac = 4'(f);
    for (int i = 0; i < 200 && !done; i++) begin
      if (cfg_ready) done = 1;
      tick(1);
    end
    cfg_valid = 1'b0;
    if (!done) chk("cfg_accept_timeout", 0, 1);
  endtask

  // Park at a cycle where the next clock edge carries no divider edge.
  task wait_quiet();
    for (int i = 0; i < 50 && (s1 && !s2); i++) tick(1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, e0, viol;
    bit hit;
    #1 reset = 1'b1;
    #1 chk_en = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(1);
    chk("rst_ndiv", int'(ndiv), 4);
    chk("rst_div_reset", int'(div_reset), 1);
    chk("rst_ready", int'(cfg_ready), 1);
    chk("rst_sat", int'(sat), 0);

    // N=5, F=0: constant ndiv, no reloads in RUN
    send_cfg(5, 0);
    chk("idle_load_ndiv", int'(ndiv), 5);
    chk("idle_load_upd", int'(ndiv_upd), 1);
    enable = 1'b1;
    cnt = 0;
    repeat (150) begin tick(1); cnt += int'(ndiv_upd); end
    chk("f0_upd_count", cnt, 0);
    chk("f0_ndiv", int'(ndiv), 5);
    chk("f0_div_reset", int'(div_reset), 0);
    enable = 1'b0;
    tick(1);
    chk("disable_div_reset", int'(div_reset), 1);
    tick(1);

    // N=5, F=4: one carry per four edges
    send_cfg(5, 4);
    enable = 1'b1;
    e0 = m_edges; cnt = 0;
    repeat (300) begin tick(1); if (ndiv_upd && ndiv == 4'd6) cnt++; end
    chk("f4_carry_rate", cnt, (m_edges - e0) / 4);
    chk("f4_edges_seen", int'((m_edges - e0) >= 20), 1);
    enable = 1'b0;
    tick(2);

    // N=15, F=8: saturates, later config clears sat
    send_cfg(15, 8);
    enable = 1'b1;
    tick(200);
    chk("sat_set", int'(sat), 1);
    chk("sat_ndiv", int'(ndiv), 15);
    wait_quiet();
    cfg_valid = 1'b1; cfg_int = 4'd7; cfg_frac = 4'd0;
    tick(1);
    cfg_valid = 1'b0;
    chk("sat_clear", int'(sat), 0);
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin tick(1); hit = ndiv_upd; end
    chk("sat_cfg_applied", int'(ndiv), 7);
    enable = 1'b0;
    tick(2);

    // coerced integer divide
    send_cfg(1, 0);
    chk("coerce_ndiv", int'(ndiv), 2);
    chk("coerce_err", int'(cfg_err), 1);
    tick(1);
    chk("coerce_err_once", int'(cfg_err), 0);

    // config accepted on the same cycle as a divider edge
    send_cfg(6, 0);
    enable = 1'b1;
    hit = 0;
    for (int i = 0; i < 400 && !hit; i++) begin
      if (m_st == 2 && s1 && !s2) hit = 1; else tick(1);
    end
    chk("coinc_edge_found", int'(hit), 1);
    cfg_valid = 1'b1; cfg_int = 4'd9; cfg_frac = 4'd0;
    tick(1);
    cfg_valid = 1'b0;
    chk("coinc_ndiv_kept", int'(ndiv), 6);
    chk("coinc_ready_low", int'(cfg_ready), 0);
    viol = 0; hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      tick(1);
      hit = ndiv_upd;
      if (!hit && cfg_ready) viol++;
    end
    chk("coinc_ready_held", viol, 0);
    chk("coinc_new_ndiv", int'(ndiv), 9);
    chk("coinc_ready_back", int'(cfg_ready), 1);

    // reset in RUN discards a pending config
    wait_quiet();
    cfg_valid = 1'b1; cfg_int = 4'd11; cfg_frac = 4'd3;
    tick(1);
    cfg_valid = 1'b0;
    chk("pend_ready_low", int'(cfg_ready), 0);
    reset = 1'b1;
    tick(1);
    chk("run_rst_div_reset", int'(div_reset), 1);
    chk("run_rst_ndiv", int'(ndiv), 4);
    reset = 1'b0;
    tick(100);
    chk("run_rst_pending_gone", int'(ndiv), 4);
    chk("run_rst_running", int'(div_reset), 0);
    enable = 1'b0;
    tick(2);

    // randomized traffic, checked every cycle by the compare process
    repeat (3000) begin
      tick(1);
      if (enable ? ($urandom_range(0, 199) == 0) : ($urandom_range(0, 9) == 0))
        enable = !enable;
      cfg_valid = ($urandom_range(0, 7) == 0);
      cfg_int   = 4'($urandom_range(0, 15));
      cfg_frac  = 4'($urandom_range(0, 15));
    end
    cfg_valid = 1'b0;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ndiv_sequencer.md
# ndiv_sequencer

Control block for the ADPLL's 4-bit programmable frequency divider. It accepts integer and fractional divide settings through a valid/ready handshake, holds the divider in reset until enabled, and drives the divider's `ndiv` input. In RUN it dithers `ndiv` between N and N+1 with a 4-bit phase accumulator, giving an average divide ratio of N + F/16. Every `ndiv` change is applied on a divider-output rising edge only, so a setting never changes in the middle of a period.

## Interface
- `DEFAULT_NDIV`, default 4: `ndiv` value at reset and in IDLE before any configuration is accepted; legal range 2..15.
- `clk`  in  1  system clock; the same clock that drives the divider.
- `reset`  in  1  asynchronous, active-high.
- `enable`  in  1  level; high requests RUN, low forces IDLE.
- `cfg_valid`  in  1  configuration offered.
- `cfg_ready`  out  1  configuration can be accepted this cycle.
- `cfg_int`  in  4  integer divide N.
- `cfg_frac`  in  4  fractional part F, in units of 1/16.
- `div_out`  in  1  the divider's `freq_div_out`, fed back.
- `ndiv`  out  4  registered divide value to the divider.
- `div_reset`  out  1  registered reset to the divider; high in IDLE.
- `ndiv_upd`  out  1  one-cycle pulse when `ndiv` is reloaded.
- `cfg_err`  out  1  one-cycle pulse when an accepted `cfg_int` was coerced.
- `sat`  out  1  sticky; set when N+1 would exceed 15; cleared on the next config acceptance or on reset.

## Operation
- **States:** IDLE, START, RUN.
- **Reset values:** state=IDLE, `ndiv`=DEFAULT_NDIV, `div_reset`=1, `ndiv_upd`=0, `cfg_err`=0, `sat`=0, accumulator=0, no pending config.
- **`cfg_ready` (combinational):** `(state==IDLE) || (state==RUN && !pending)`. A config is accepted when `cfg_valid && cfg_ready`.
- **Coercion:** an accepted `cfg_int` of 0 or 1 is stored as 2 and `cfg_err` pulses on the next cycle.
- **IDLE:**
  - An accepted config loads N and F immediately and clears the accumulator.
  - `ndiv` takes N on the next cycle and `ndiv_upd` pulses.
  - When `enable`=1, go to START.
- **START** (1 cycle): deassert `div_reset`, then go to RUN.
- **RUN:**
  - A rising edge of `div_out` is detected against a registered copy of `div_out`; call it `edge`.
  - On each `edge`, the accumulator computes `{c, acc} = acc + F`. `ndiv` becomes N+c, saturated at 15; saturation sets `sat`.
  - An accepted config becomes pending. At the next `edge` it is applied: N and F are updated, the accumulator is cleared, and `ndiv` becomes the new N with no carry. The pending flag then clears.
  - `ndiv_upd` pulses on every `ndiv` reload.
- **`enable`=0 in START or RUN:** go to IDLE next cycle and assert `div_reset`. Any pending config is kept and is applied on the IDLE entry cycle. The accumulator is cleared.
- **Simultaneous events:**
  - `enable` fall together with `edge`: `enable` wins and the accumulator does not advance.
  - Config acceptance in the same cycle as `edge`: that edge uses the old N and F; the new config waits for the following edge.
- **Asynchronous reset at any point:** returns all state and outputs to their reset values. Any pending config is discarded.

## Timing
- `div_out` rising at clock edge k → `edge` asserted in cycle k+1 → `ndiv` and `ndiv_upd` registered at clock edge k+2.
- `enable` rising in IDLE (sampled at clock edge t) → START at t+1 → `div_reset`=0 from t+2 → RUN.
- `enable` falling in RUN (sampled at clock edge t) → `div_reset`=1 from t+1.
- Config accepted in IDLE at clock edge t → `ndiv` updated at t+1.
- Config accepted in RUN → `cfg_ready` low until the `ndiv_upd` that applies it.
- Width rule: N+1 is computed in 5 bits, then clamped to 15.

## Structure
- **`adpll_pkg`:** the state enum (IDLE/START/RUN), `NDIV_MIN`=2, `NDIV_MAX`=15, `NDIV_W`=4, `FRAC_W`=4. The divider shares these.
- **Sub-module `ndiv_frac_accum`:** holds the accumulator register. Inputs are step, clear and F; outputs are carry and the saturating N+c result.
- **Top level:** the FSM, the pending-config register and the edge detector.

## Test plan
- N=5, F=0, `enable`=1 → `ndiv` stays 5; `div_out` period is 12 clocks; `ndiv_upd` pulses only on the IDLE load.
- N=5, F=4 → `ndiv` over successive edges is 5,5,5,6 repeating; average ratio 5.25.
- N=15, F=8 → `ndiv` stays 15; `sat` goes high on the first carry and stays high; a later config with N=7 clears it.
- `cfg_int`=1 accepted in IDLE → `ndiv`=2 and a single `cfg_err` pulse.
- In RUN with N=6, a config N=9 is accepted in the same cycle as `edge` → that edge keeps N=6; the next edge loads 9 with the accumulator cleared; `cfg_ready` is low in between.
- `enable` dropped mid-period, and separately `reset` pulsed in RUN → `div_reset`=1 next cycle; after `reset`, `ndiv`=DEFAULT_NDIV and the pending config is gone.
